regfile_sb: RTL and testbench

- Parametrised successor to the single-cycle core's register unit. Provides an N-read / 1-write integer register file with configurable width and depth.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass.
- A per-register busy scoreboard lets the upcoming pipelined core detect RAW hazards on in-flight results. Sits between decode (read/reserve) and writeback (write/release).

---
 rtl/regfile_sb.sv | 102 ++++++++++
 tb/tb_regfile_sb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: NRD-read / 1-write integer register file with a per-register busy
// scoreboard for RAW hazard detection in a pipelined core.
//
// Ports:
//   CLK       rising-edge clock
//   RSTn      asynchronous active-low reset (clears data, busy bits and pend_cnt)
//   rs_addr   NRD packed read addresses, port k at [k*AW +: AW]
//   rs_data   NRD packed read data, port k at [k*XLEN +: XLEN] (combinational)
//   rs_busy   per-port: addressed register has an outstanding, unbypassed producer
//   wr_en     writeback strobe; writes wr_data to wr_addr and releases its busy bit
//   wr_addr   writeback destination
//   wr_data   writeback data
//   rsv_en    reserve (mark busy) rsv_addr at issue
//   rsv_addr  register to reserve
//   pend_cnt  registered count of busy registers
module regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [AW:0]         pend_cnt
);

  localparam logic [AW:0] CntOne = (AW + 1)'(1);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      pend_q, pend_d;

  logic wr_ok, rsv_ok;
  logic set_new, clr_old;

  // Writes and reservations to the hardwired zero register are dropped here so
  // neither the data array nor the scoreboard ever see them.
  assign wr_ok  = wr_en  && !((ZERO_REG == 1) && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG == 1) && (rsv_addr == '0));

  // Counter deltas: a set only counts on a clear bit; a release only counts when
  // the same register is not being re-reserved in this cycle (set wins).
  assign set_new = rsv_ok && !busy_q[rsv_addr];
  assign clr_old = wr_ok && busy_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));

  always_comb begin
    busy_d = busy_q;
    if (wr_ok)  busy_d[wr_addr]  = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
  end

  always_comb begin
    pend_d = pend_q;
    unique case ({set_new, clr_old})
      2'b10:   pend_d = pend_q + CntOne;
      2'b01:   pend_d = pend_q - CntOne;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      if (wr_ok) regs_q[wr_addr] <= wr_data;
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign pend_cnt = pend_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          byp;

    assign addr    = rs_addr[k*AW +: AW];
    assign is_zero = (ZERO_REG == 1) && (addr == '0);
    // Bypass forwards this cycle's writeback; the producer is then no longer
    // outstanding from the reader's point of view.
    assign byp     = (BYPASS == 1) && RSTn && wr_en && (wr_addr == addr) && !is_zero;

    assign rs_data[k*XLEN +: XLEN] = (!RSTn || is_zero) ? '0 :
                                     byp                ? wr_data :
                                                          regs_q[addr];
    assign rs_busy[k] = RSTn && !is_zero && !byp && busy_q[addr];
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a bypassing and a non-bypassing instance
// share stimulus and are compared every cycle against an array/popcount model.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                CLK = 1'b0;
  logic                RSTn = 1'b0;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data_b, rs_data_n;
  logic [NRD-1:0]      rs_busy_b, rs_busy_n;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic [AW:0]         pend_b, pend_n;

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .rs_addr(rs_addr), .rs_data(rs_data_b), .rs_busy(rs_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .pend_cnt(pend_b)
  );

  regfile_sb #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .CLK(CLK), .RSTn(RSTn), .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_busy(rs_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .pend_cnt(pend_n)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: plain arrays of register contents and busy flags.
  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic int popcnt();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] exp_data(input int a, input bit byp);
    if (!RSTn || a == 0) return '0;
    if (byp && wr_en && int'(wr_addr) == a) return wr_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit byp);
    if (!RSTn || a == 0) return 1'b0;
    if (byp && wr_en && int'(wr_addr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_all();
    for (int k = 0; k < NRD; k++) begin
      int a;
      a = int'(rs_addr[k*AW +: AW]);
      chk("data_byp",   rs_data_b[k*XLEN +: XLEN], exp_data(a, 1'b1));
      chk("data_nobyp", rs_data_n[k*XLEN +: XLEN], exp_data(a, 1'b0));
      chk("busy_byp",   rs_busy_b[k], exp_busy(a, 1'b1));
      chk("busy_nobyp", rs_busy_n[k], exp_busy(a, 1'b0));
    end
    chk("pend_byp",   pend_b, popcnt());
    chk("pend_nobyp", pend_n, popcnt());
  endtask

  // Model state advance: sees the inputs that were stable across the edge.
  initial forever begin
    @(posedge CLK);
    if (RSTn) begin
      if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
      if (wr_en) m_busy[wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  // Compare process: opposite edge to the active one.
  initial forever begin
    @(negedge CLK);
    check_all();
  end

  task automatic apply(input bit we, input int wa, input logic [31:0] wd,
                       input bit re, input int ra, input int a0, input int a1);
    wr_en    = we;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = AW'(ra);
    rs_addr  = {AW'(a1), AW'(a0)};
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    model_clear();
    apply(0, 0, 0, 0, 0, 0, 0);
    RSTn = 1'b0;
    step();
    step();
    RSTn = 1'b1;
    chk("rst_pend", pend_b, 0);

    // Write + reserve x5, then async reset without a clock edge
    apply(1, 5, 32'h1234, 1, 5, 5, 5);
    step();
    apply(0, 0, 0, 0, 0, 5, 0);
    #2;
    chk("x5_data", rs_data_b[31:0], 32'h1234);
    chk("x5_busy", rs_busy_b[0], 1);
    chk("x5_pend", pend_b, 1);
    RSTn = 1'b0;
    model_clear();
    #1;
    chk("rst_data", rs_data_b[31:0], 0);
    chk("rst_busy", rs_busy_b, 0);
    chk("rst_pend_mid", pend_b, 0);
    chk("rst_pend_nb", pend_n, 0);
    step();
    RSTn = 1'b1;
    #2;
    chk("x5_after_rst", rs_data_b[31:0], 0);
    chk("busy_after_rst", rs_busy_b[0], 0);
    step();

    // Zero register ignores write and reservation
    apply(1, 0, 32'hDEADBEEF, 1, 0, 0, 0);
    #2;
    chk("x0_data", rs_data_b[31:0], 0);
    chk("x0_busy", rs_busy_b[0], 0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("x0_pend", pend_b, 0);
    chk("x0_data_after", rs_data_b[63:32], 0);

    // Bypass on both ports vs. no bypass
    apply(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7);
    #2;
    chk("byp_p0", rs_data_b[31:0], 32'hA5A5A5A5);
    chk("byp_p1", rs_data_b[63:32], 32'hA5A5A5A5);
    chk("nobyp_old", rs_data_n[31:0], 0);
    step();
    apply(0, 0, 0, 0, 0, 7, 7);
    #2;
    chk("nobyp_new", rs_data_n[63:32], 32'hA5A5A5A5);

    // RAW on x3
    apply(0, 0, 0, 1, 3, 3, 0);
    step();
    apply(0, 0, 0, 0, 0, 3, 0);
    #2;
    chk("raw_busy", rs_busy_b[0], 1);
    chk("raw_pend", pend_b, 1);
    step();
    step();
    step();
    apply(1, 3, 42, 0, 0, 3, 3);
    #2;
    chk("raw_byp_busy", rs_busy_b[0], 0);
    chk("raw_nb_busy", rs_busy_n[0], 1);
    chk("raw_byp_data", rs_data_b[31:0], 42);
    step();
    apply(0, 0, 0, 0, 0, 3, 3);
    #2;
    chk("raw_pend_done", pend_b, 0);
    chk("raw_reg3", rs_data_n[31:0], 42);

    // Simultaneous reserve + write on busy x9
    apply(0, 0, 0, 1, 9, 9, 9);
    step();
    apply(1, 9, 32'h99, 1, 9, 9, 9);
    step();
    apply(0, 0, 0, 0, 0, 9, 9);
    #2;
    chk("x9_data", rs_data_b[31:0], 32'h99);
    chk("x9_busy", rs_busy_b[0], 1);
    chk("x9_pend", pend_b, 1);
    // Reserve x4 while releasing busy x6
    apply(0, 0, 0, 1, 6, 6, 6);
    step();
    apply(1, 6, 32'h66, 1, 4, 4, 6);
    step();
    apply(0, 0, 0, 0, 0, 4, 6);
    #2;
    chk("move_pend", pend_b, 2);
    chk("move_x4_busy", rs_busy_b[0], 1);
    chk("move_x6_busy", rs_busy_b[1], 0);
    chk("move_x6_data", rs_data_b[63:32], 32'h66);
    apply(1, 9, 1, 0, 0, 0, 0);
    step();
    apply(1, 4, 2, 0, 0, 0, 0);
    step();
    apply(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("release_pend", pend_b, 0);

    // Fill the scoreboard
    for (int i = 1; i < NREGS; i++) begin
      apply(0, 0, 0, 1, i, i, 0);
      step();
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("fill_pend", pend_b, 31);
    apply(0, 0, 0, 1, 10, 10, 0);
    step();
    apply(0, 0, 0, 0, 0, 10, 0);
    #2;
    chk("waw_pend", pend_b, 31);
    chk("waw_busy", rs_busy_b[0], 1);
    for (int i = 1; i < NREGS; i++) begin
      apply(1, i, 32'(i * 3), 0, 0, i, 0);
      step();
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("drain_pend", pend_b, 0);

    // Random traffic, biased to a small address window for collisions
    for (int n = 0; n < 3000; n++) begin
      int wa, ra, a0, a1;
      if ($urandom_range(0, 299) == 0) begin
        apply(0, 0, 0, 0, 0, 0, 0);
        #2;
        RSTn = 1'b0;
        model_clear();
        step();
        RSTn = 1'b1;
      end
      wa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, 7));
      apply(bit'($urandom_range(0, 1)), wa, $urandom(), bit'($urandom_range(0, 1)), ra, a0, a1);
      step();
    end

    apply(0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
